// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, bus owner, counter sizing.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_BUSY_I = 2'b01,
        ARB_BUSY_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int PERF_CNT_W = 16;

    // Width able to hold 0..max; a zero limit still needs one bit.
    function automatic int starve_cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants won against a pending fetch; sat_o hands the next conflict to fetch.
module mem_arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CNT_W = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory; each access holds the bus from grant to mem_ack.
// Optional MEM_ARB_PERF_EN adds a saturating conflict_cnt of IDLE cycles with both ports requesting.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] conflict_cnt
`endif
);

    arb_state_t        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic       in_idle;
    logic       busy;
    logic       starve_sat;
    logic       win_data;
    logic       win_fetch;
    arb_owner_t owner;

    assign in_idle = (state_q == ARB_IDLE);
    assign busy    = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);

    // Data wins by default; a saturated starvation count flips a conflict to fetch.
    assign win_data  = in_idle && d_req && !(if_req && starve_sat);
    assign win_fetch = in_idle && if_req && !win_data;

    mem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc_i(win_data && if_req),
        .clr_i(win_fetch),
        .sat_o(starve_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win_data) begin
                        state_q     <= ARB_BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                    end else if (win_fetch) begin
                        state_q    <= ARB_BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (mem_ack) begin
                        state_q   <= ARB_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Completion is combinational on mem_ack; a reset cycle never completes the abandoned access.
    assign owner    = (state_q == ARB_BUSY_D) ? OWN_D : OWN_I;
    assign if_ack   = !rst && busy && mem_ack && (owner == OWN_I);
    assign d_ack    = !rst && busy && mem_ack && (owner == OWN_D);
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign d_rdata  = d_ack ? mem_rdata : '0;
    assign if_stall = if_req && !if_ack;
    assign d_stall  = d_req && !d_ack;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else if (in_idle && if_req && d_req && (conflict_cnt_q != {PERF_CNT_W{1'b1}})) begin
            conflict_cnt_q <= conflict_cnt_q + 1'b1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: grant/ack queues filled at drive time, drained by a monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        int          own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we, mem_ack;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    logic        mdl_ack   = 1'b0;
    logic        man_ack   = 1'b0;
    logic [31:0] mdl_rdata = '0;
    assign mem_ack   = mdl_ack | man_ack;
    assign mem_rdata = mdl_rdata;

    int          n_chk = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    bit          mem_manual = 1'b0;
    logic [31:0] mem_arr [logic [31:0]];
    gnt_t        grant_q [$];
    logic [31:0] d_exp_q [$];
    logic [31:0] if_exp_q [$];
    int          cyc_cnt = 0;
    int          gnt_cyc [2];
    int          ack_cyc [2];
    int          cur_own = -1;
    bit          req_prev = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_ARB_PERF_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_gnt(input int own, input logic we, input logic [31:0] a, input logic [31:0] wd);
        gnt_t g;
        g.own = own; g.we = we; g.addr = a; g.wdata = wd;
        grant_q.push_back(g);
    endtask

    // Memory: acks mem_lat cycles after mem_req is seen, unless the test drives mem_ack by hand.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_arr[32'h100] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            if (mdl_ack) begin
                mdl_ack = 1'b0;
                mdl_rdata = '0;
                wcnt = 0;
            end else if (mem_req && !mem_manual) begin
                wcnt++;
                if (wcnt >= mem_lat) begin
                    mdl_ack = 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mdl_rdata = '0;
                    end else begin
                        mdl_rdata = rd_model(mem_addr);
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        gnt_t g;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (mem_req && !req_prev) begin
                if (grant_q.size() == 0) begin
                    chk("gnt_unexpected", 1, 0);
                end else begin
                    g = grant_q.pop_front();
                    cur_own = g.own;
                    gnt_cyc[g.own] = cyc_cnt;
                    chk("gnt_we", mem_we, g.we);
                    chk("gnt_addr", mem_addr, g.addr);
                    if (g.we) chk("gnt_wdata", mem_wdata, g.wdata);
                end
            end
            if (d_ack) begin
                ack_cyc[1] = cyc_cnt;
                chk("d_ack_owner", cur_own, 1);
                chk("d_ack_excl", if_ack, 0);
                if (d_exp_q.size() == 0) chk("d_ack_unexp", 1, 0);
                else chk("d_rdata", d_rdata, d_exp_q.pop_front());
            end
            if (if_ack) begin
                ack_cyc[0] = cyc_cnt;
                chk("if_ack_owner", cur_own, 0);
                if (if_exp_q.size() == 0) chk("if_ack_unexp", 1, 0);
                else chk("if_rdata", if_rdata, if_exp_q.pop_front());
            end
            req_prev = mem_req;
        end
    end

    // Issues n data accesses back to back, updating the request at each ack edge.
    task automatic do_data_seq(input int n, input logic we, input logic [31:0] base,
                               output int ack1, output int req1);
        bit got;
        int cnt;
        ack1 = 0; req1 = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            d_req = 1'b1; d_we = we; d_addr = base + 32'(4 * i); d_wdata = 32'h55 + 32'(i);
            d_exp_q.push_back(we ? 32'h0 : rd_model(d_addr));
            got = 1'b0; cnt = 0;
            for (int k = 0; k < 64 && !got; k++) begin
                @(negedge clk);
                cnt++;
                if (i == 0 && req1 == 0 && mem_req) req1 = cnt;
                if (d_ack) begin
                    got = 1'b1;
                    chk("d_stall_at_ack", d_stall, 0);
                end else begin
                    chk("d_stall_wait", d_stall, 1);
                    chk("d_rdata_idle", d_rdata, 0);
                end
            end
            if (!got) chk("d_timeout", 0, 1);
            if (i == 0) ack1 = cnt;
            @(posedge clk); #1;
        end
        d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        bit got;
        if_exp_q.push_back(rd_model(a));
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (if_ack) got = 1'b1;
        end
        if (!got) chk("if_timeout", 0, 1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c1, r1, n;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // Load with 3-cycle memory latency.
        mem_lat = 3;
        push_gnt(1, 1'b0, 32'h100, 32'h0);
        do_data_seq(1, 1'b0, 32'h100, c1, r1);
        chk("t1_req_cycle", r1, 2);
        chk("t1_ack_cycle", c1, 4);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack || if_ack) n++;
        end
        chk("t1_single_ack", n, 0);

        // Conflict: store first, one IDLE cycle, then the fetch.
        mem_lat = 1;
        push_gnt(1, 1'b1, 32'h200, 32'h55);
        push_gnt(0, 1'b0, 32'h0, 32'h0);
        fork
            do_data_seq(1, 1'b1, 32'h200, c1, r1);
            do_fetch(32'h0);
        join
        chk("t2_idle_gap", gnt_cyc[0] - ack_cyc[1], 2);
        chk("t2_store_mem", mem_arr[32'h200], 32'h55);

        // Starvation: three data wins, then fetch.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_gnt(1, 1'b0, 32'h300, 32'h0);
        push_gnt(1, 1'b0, 32'h304, 32'h0);
        push_gnt(1, 1'b0, 32'h308, 32'h0);
        push_gnt(0, 1'b0, 32'h40, 32'h0);
        push_gnt(1, 1'b0, 32'h30C, 32'h0);
        fork
            do_data_seq(4, 1'b0, 32'h300, c1, r1);
            do_fetch(32'h40);
        join
        chk("t3_starve_cnt", dut.u_starve.cnt_q, 0);
`ifdef MEM_ARB_PERF_EN
        chk("t6_conflicts", conflict_cnt, 4);
`endif

        // Reset in the middle of a data access, then a late mem_ack.
        mem_manual = 1'b1;
        push_gnt(1, 1'b0, 32'h400, 32'h0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        repeat (3) @(negedge clk);
        chk("t4_busy", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t4_req_after_rst", mem_req, 0);
        chk("t4_d_ack_rst", d_ack, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 man_ack = 1'b1;
        @(negedge clk);
        chk("t4_late_d_ack", d_ack, 0);
        chk("t4_late_if_ack", if_ack, 0);
        chk("t4_late_rdata", d_rdata, 0);
        chk("t4_state", dut.state_q, 0);
        @(posedge clk); #1 man_ack = 1'b0;
`ifdef MEM_ARB_PERF_EN
        chk("t6_conflicts_rst", conflict_cnt, 0);
`endif

        // Spurious ack while IDLE.
        @(posedge clk); #1 man_ack = 1'b1;
        @(negedge clk);
        chk("t5_if_ack", if_ack, 0);
        chk("t5_d_ack", d_ack, 0);
        @(posedge clk); #1 man_ack = 1'b0;
        @(negedge clk);
        chk("t5_state", dut.state_q, 0);
        chk("t5_mem_req", mem_req, 0);

        // Normal fetch after the disturbances.
        mem_manual = 1'b0;
        mem_lat = 2;
        push_gnt(0, 1'b0, 32'h80, 32'h0);
        do_fetch(32'h80);

        repeat (2) @(negedge clk);
        chk("sb_empty", grant_q.size() + d_exp_q.size() + if_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
